tx_pipe_arbiter: RTL and testbench

- Merges NUM_CH independent byte producers onto one downstream UART tx pipe. Typical producers are the CU putc path, the loader echo path and debug sources.
- Each channel has its own FIFO of DEPTH entries.
- A registered arbiter issues one byte at a time, in round-robin or fixed-priority order, using the tx pipe push_back/full handshake.
- An optional line-lock mode keeps a channel granted until it sends a newline, so lines from different sources never interleave.

---
 rtl/tx_pipe_arbiter.sv | 170 +++++++++++++++++
 tb/tb_tx_pipe_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/tx_pipe_arbiter.sv
// Merges NUM_CH byte producers, each behind its own small FIFO, onto one downstream tx pipe.
// A registered arbiter issues at most one byte every two cycles, optionally holding a channel for a whole line.
module tx_pipe_arbiter #(
    parameter int NUM_CH       = 2,
    parameter int DEPTH        = 4,
    parameter int DATA_W       = 8,
    parameter int MODE         = 0,
    parameter int LINE_LOCK    = 0,
    parameter int LOCK_TIMEOUT = 1024,
    localparam int GW          = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_push,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_full,
    output logic [NUM_CH-1:0]        ch_overflow,
    output logic                     out_push_back,
    output logic [DATA_W-1:0]        out_data,
    input  logic                     out_full,
    output logic [GW-1:0]            grant,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);

    logic [DATA_W-1:0] mem_q [NUM_CH][DEPTH];
    logic [PW-1:0]     wr_ptr_q [NUM_CH];
    logic [PW-1:0]     rd_ptr_q [NUM_CH];
    logic [NUM_CH-1:0] overflow_q;
    logic [NUM_CH-1:0] avail_q;
    logic              push_back_q;
    logic [DATA_W-1:0] data_q;
    logic [GW-1:0]     grant_q;
    logic [GW-1:0]     rr_q;
    logic              lock_q;
    logic [GW-1:0]     lock_ch_q;
    logic [TW-1:0]     tmo_q;

    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] push_ok;
    logic [NUM_CH-1:0] cand;
    logic              found;
    logic [GW-1:0]     win;
    logic              issue;
    logic [DATA_W-1:0] sel_byte;
    logic              is_nl;

    function automatic logic [GW-1:0] nextCh(input logic [GW-1:0] c);
        return (int'(c) == NUM_CH - 1) ? '0 : c + 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            empty[i]   = (wr_ptr_q[i] == rd_ptr_q[i]);
            ch_full[i] = (wr_ptr_q[i][PW-1] != rd_ptr_q[i][PW-1]) &&
                         (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
            push_ok[i] = ch_push[i] && !ch_full[i];
        end
    end

    // avail_q lags the FIFOs by one cycle; the mandatory idle cycle after each strobe
    // hides the stale entry of a channel that was just drained.
    always_comb begin
        cand  = '0;
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand[i] = avail_q[i] && (!lock_q || (int'(lock_ch_q) == i));
        end
        if (MODE == 1) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (cand[i]) begin
                    found = 1'b1;
                    win   = GW'(i);
                end
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                int idx;
                idx = (int'(rr_q) + k) % NUM_CH;
                if (!found && cand[idx]) begin
                    found = 1'b1;
                    win   = GW'(idx);
                end
            end
        end
        issue    = found && !push_back_q && !out_full;
        sel_byte = mem_q[win][rd_ptr_q[win][AW-1:0]];
        is_nl    = (sel_byte == DATA_W'(10));
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push_ok[i]) begin
                mem_q[i][wr_ptr_q[i][AW-1:0]] <= ch_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
            overflow_q  <= '0;
            avail_q     <= '0;
            push_back_q <= 1'b0;
            data_q      <= '0;
            grant_q     <= '0;
            rr_q        <= '0;
            lock_q      <= 1'b0;
            lock_ch_q   <= '0;
            tmo_q       <= '0;
        end else begin
            avail_q     <= ~empty;
            push_back_q <= issue;
            for (int i = 0; i < NUM_CH; i++) begin
                if (push_ok[i]) begin
                    wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
                end
                if (ch_push[i] && ch_full[i]) begin
                    overflow_q[i] <= 1'b1;
                end
                if (issue && (int'(win) == i)) begin
                    rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
                end
            end
            if (issue) begin
                data_q  <= sel_byte;
                grant_q <= win;
            end
            // With line lock the round-robin pointer only moves when a line ends or times out.
            if (issue) begin
                if (LINE_LOCK != 0) begin
                    tmo_q <= '0;
                    if (is_nl) begin
                        lock_q <= 1'b0;
                        rr_q   <= nextCh(win);
                    end else begin
                        lock_q    <= 1'b1;
                        lock_ch_q <= win;
                    end
                end else begin
                    rr_q <= nextCh(win);
                end
            end else if ((LINE_LOCK != 0) && lock_q) begin
                if (!empty[lock_ch_q] || ch_push[lock_ch_q]) begin
                    tmo_q <= '0;
                end else if (tmo_q == TW'(LOCK_TIMEOUT - 1)) begin
                    tmo_q  <= '0;
                    lock_q <= 1'b0;
                    rr_q   <= nextCh(lock_ch_q);
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end
        end
    end

    assign ch_overflow   = overflow_q;
    assign out_push_back = push_back_q;
    assign out_data      = data_q;
    assign grant         = grant_q;
    assign busy          = (|(~empty)) | push_back_q;

endmodule

// File: tb/tb_tx_pipe_arbiter.sv
// Scoreboard bench for tx_pipe_arbiter: three instances cover round-robin, fixed priority and line lock.
// Expected bytes are queued as stimulus is driven and popped whenever the selected instance strobes.
module tb_tx_pipe_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] chPush [3];
    logic [15:0] chData [3];
    logic       outFull [3];
    logic [1:0] chFull [3];
    logic [1:0] chOvf [3];
    logic       outPush [3];
    logic [7:0] outData [3];
    logic [0:0] grant [3];
    logic       busy [3];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int sel = 0;
    logic prevPush = 1'b0;
    logic [7:0] expQ [$];
    int strobeCyc [$];

    always #5 clk = ~clk;

    tx_pipe_arbiter #(.NUM_CH(2), .DEPTH(4), .DATA_W(8), .MODE(0), .LINE_LOCK(0), .LOCK_TIMEOUT(1024)) dutRr (
        .clk(clk), .rst(rst), .ch_push(chPush[0]), .ch_data(chData[0]), .ch_full(chFull[0]),
        .ch_overflow(chOvf[0]), .out_push_back(outPush[0]), .out_data(outData[0]),
        .out_full(outFull[0]), .grant(grant[0]), .busy(busy[0]));

    tx_pipe_arbiter #(.NUM_CH(2), .DEPTH(4), .DATA_W(8), .MODE(1), .LINE_LOCK(0), .LOCK_TIMEOUT(1024)) dutPri (
        .clk(clk), .rst(rst), .ch_push(chPush[1]), .ch_data(chData[1]), .ch_full(chFull[1]),
        .ch_overflow(chOvf[1]), .out_push_back(outPush[1]), .out_data(outData[1]),
        .out_full(outFull[1]), .grant(grant[1]), .busy(busy[1]));

    tx_pipe_arbiter #(.NUM_CH(2), .DEPTH(4), .DATA_W(8), .MODE(0), .LINE_LOCK(1), .LOCK_TIMEOUT(16)) dutLock (
        .clk(clk), .rst(rst), .ch_push(chPush[2]), .ch_data(chData[2]), .ch_full(chFull[2]),
        .ch_overflow(chOvf[2]), .out_push_back(outPush[2]), .out_data(outData[2]),
        .out_full(outFull[2]), .grant(grant[2]), .busy(busy[2]));

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // One push edge on instance d; ch0 gets b0 and ch1 gets b1 where the push mask says so.
    task automatic applyStimulus(input int d, input logic [1:0] push, input logic [7:0] b0, input logic [7:0] b1);
        chPush[d] = push;
        chData[d] = {b1, b0};
        @(posedge clk);
        #1;
        chPush[d] = 2'b00;
    endtask

    task automatic waitDrain(input int d, input int maxCyc);
        int n = 0;
        while ((expQ.size() != 0 || busy[d] !== 1'b0) && n < maxCyc) begin
            @(negedge clk);
            n++;
        end
        #1;
        checkOutput("drainedInTime", {31'd0, (expQ.size() != 0 || busy[d] !== 1'b0)}, 0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard side: every strobe of the selected instance must match the oldest expected byte.
    always @(negedge clk) begin
        if (outPush[sel] === 1'b1) begin
            checkOutput("noBackToBack", {31'd0, prevPush}, 0);
            strobeCyc.push_back(cyc);
            checkOutput("strobeExpected", {31'd0, expQ.size() > 0}, 1);
            if (expQ.size() > 0) begin
                checkOutput("outData", {24'd0, outData[sel]}, {24'd0, expQ.pop_front()});
            end
        end
        prevPush <= outPush[sel];
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int gap;
        int n;
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            chPush[d]  = 2'b00;
            chData[d]  = 16'h0000;
            outFull[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        checkOutput("rstOutPush", {31'd0, outPush[0]}, 0);
        checkOutput("rstOutData", {24'd0, outData[0]}, 0);
        checkOutput("rstGrant", {31'd0, grant[0]}, 0);
        checkOutput("rstBusy", {31'd0, busy[0]}, 0);
        checkOutput("rstFull", {30'd0, chFull[0]}, 0);
        checkOutput("rstOvf", {30'd0, chOvf[0]}, 0);
        checkOutput("rstLockBusy", {31'd0, busy[2]}, 0);

        $display("[TB] single byte latency");
        expQ.push_back(8'h41);
        applyStimulus(0, 2'b10, 8'h00, 8'h41);
        @(negedge clk);
        checkOutput("latCyc0", {31'd0, outPush[0]}, 0);
        @(negedge clk);
        checkOutput("latCyc1", {31'd0, outPush[0]}, 0);
        @(negedge clk);
        checkOutput("latCyc2", {31'd0, outPush[0]}, 1);
        checkOutput("latData", {24'd0, outData[0]}, 32'h41);
        checkOutput("latGrant", {31'd0, grant[0]}, 1);
        @(negedge clk);
        checkOutput("latCyc3Strobe", {31'd0, outPush[0]}, 0);
        @(negedge clk);
        checkOutput("latBusyCyc4", {31'd0, busy[0]}, 0);

        $display("[TB] round-robin fairness");
        outFull[0] = 1'b1;
        expQ.push_back(8'h01); expQ.push_back(8'h11);
        expQ.push_back(8'h02); expQ.push_back(8'h12);
        applyStimulus(0, 2'b11, 8'h01, 8'h11);
        applyStimulus(0, 2'b11, 8'h02, 8'h12);
        base = strobeCyc.size();
        outFull[0] = 1'b0;
        waitDrain(0, 40);
        checkOutput("rrStrobeCount", strobeCyc.size() - base, 4);
        if (strobeCyc.size() >= base + 4) begin
            for (int i = 1; i < 4; i++) begin
                checkOutput("rrSpacing", strobeCyc[base+i] - strobeCyc[base+i-1], 2);
            end
        end

        $display("[TB] fixed priority with backpressure");
        sel = 1;
        outFull[1] = 1'b1;
        expQ.push_back(8'hA0); expQ.push_back(8'hB0);
        applyStimulus(1, 2'b10, 8'h00, 8'hB0);
        applyStimulus(1, 2'b01, 8'hA0, 8'h00);
        base = strobeCyc.size();
        repeat (10) @(negedge clk);
        checkOutput("noStrobeWhileFull", strobeCyc.size() - base, 0);
        #1 outFull[1] = 1'b0;
        waitDrain(1, 40);
        checkOutput("priStrobeCount", strobeCyc.size() - base, 2);
        checkOutput("priGrant", {31'd0, grant[1]}, 1);

        $display("[TB] overflow");
        sel = 0;
        outFull[0] = 1'b1;
        base = strobeCyc.size();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) expQ.push_back(8'h50 + 8'(i));
            applyStimulus(0, 2'b01, 8'h50 + 8'(i), 8'h00);
            @(negedge clk);
            checkOutput($sformatf("ovfFull%0d", i), {31'd0, chFull[0][0]}, {31'd0, i >= 3});
            checkOutput($sformatf("ovfFlag%0d", i), {31'd0, chOvf[0][0]}, {31'd0, i == 4});
        end
        #1 outFull[0] = 1'b0;
        waitDrain(0, 40);
        checkOutput("ovfStrobeCount", strobeCyc.size() - base, 4);
        checkOutput("ovfSticky", {30'd0, chOvf[0]}, 1);
        checkOutput("ovfFullCleared", {30'd0, chFull[0]}, 0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("ovfClearedByRst", {30'd0, chOvf[0]}, 0);

        $display("[TB] line lock");
        sel = 2;
        expQ.push_back(8'h68); expQ.push_back(8'h69); expQ.push_back(8'h0A);
        expQ.push_back(8'h6F); expQ.push_back(8'h6B); expQ.push_back(8'h0A);
        applyStimulus(2, 2'b11, 8'h68, 8'h6F);
        applyStimulus(2, 2'b11, 8'h69, 8'h6B);
        applyStimulus(2, 2'b11, 8'h0A, 8'h0A);
        waitDrain(2, 60);
        expQ.push_back(8'h61); expQ.push_back(8'h62);
        expQ.push_back(8'h78); expQ.push_back(8'h0A);
        base = strobeCyc.size();
        applyStimulus(2, 2'b11, 8'h61, 8'h78);
        applyStimulus(2, 2'b11, 8'h62, 8'h0A);
        waitDrain(2, 100);
        checkOutput("lockStrobeCount", strobeCyc.size() - base, 4);
        if (strobeCyc.size() >= base + 4) begin
            gap = strobeCyc[base+2] - strobeCyc[base+1];
            checkOutput($sformatf("lockReleaseGap=%0d", gap), {31'd0, (gap >= 17 && gap <= 19)}, 1);
        end

        $display("[TB] reset mid-stream");
        sel = 0;
        outFull[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expQ.push_back(8'h90 + 8'(i));
            applyStimulus(0, 2'b01, 8'h90 + 8'(i), 8'h00);
        end
        outFull[0] = 1'b0;
        n = 0;
        while (outPush[0] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        #1;
        checkOutput("midStrobeSeen", {31'd0, outPush[0]}, 1);
        expQ.delete();
        base = strobeCyc.size();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("midRstOutPush", {31'd0, outPush[0]}, 0);
        checkOutput("midRstOutData", {24'd0, outData[0]}, 0);
        checkOutput("midRstGrant", {31'd0, grant[0]}, 0);
        checkOutput("midRstBusy", {31'd0, busy[0]}, 0);
        checkOutput("midRstFull", {30'd0, chFull[0]}, 0);
        repeat (10) @(negedge clk);
        checkOutput("midNoStrobeAfterRst", strobeCyc.size() - base, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
